binary_to_bcd_seq: RTL

//  Sequential binary-to-BCD converter (iterative shift-add-3 / double-dabble).

---
 rtl/binary_to_bcd_seq_pkg.sv | 21 ++
 rtl/binary_to_bcd_seq_if.sv | 37 +++
 rtl/binary_to_bcd_seq_adjust.sv | 22 ++
 rtl/binary_to_bcd_seq.sv | 103 ++++++++++
 4 files changed

// File: rtl/binary_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_seq_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter.
// Revision    : 1.0 - initial release
// ============================================================================
package binary_to_bcd_seq_pkg;

    localparam int c_BCD_DIGIT_W = 4;

    localparam logic [c_BCD_DIGIT_W-1:0] c_ADD3_THRESHOLD = 4'd5;
    localparam logic [c_BCD_DIGIT_W-1:0] c_ADD3_VALUE     = 4'd3;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

endpackage : binary_to_bcd_seq_pkg
`default_nettype wire

// File: rtl/binary_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_seq_if
// Description : Request/result bundle between a client and the converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface binary_to_bcd_seq_if
    import binary_to_bcd_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 3
);

    logic                       start;
    logic [N-1:0]               bin;
    logic                       busy;
    logic                       done;
    logic [c_BCD_DIGIT_W*D-1:0] bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );

endinterface : binary_to_bcd_seq_if
`default_nettype wire

// File: rtl/binary_to_bcd_seq_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adjust
// Description : Double-dabble digit correction: d+3 when d>=5, else d.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import binary_to_bcd_seq_pkg::*;
(
    input  wire logic [c_BCD_DIGIT_W-1:0] i_digit,
    output logic      [c_BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= c_ADD3_THRESHOLD) begin
            o_digit = i_digit + c_ADD3_VALUE;
        end
    end

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_seq
// Description : Iterative shift-add-3 binary-to-BCD converter, one bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd_seq
    import binary_to_bcd_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 3
)(
    input  wire logic          clk,
    input  wire logic          reset,
    binary_to_bcd_seq_if.slave bus
);

    localparam int c_ITER_W = $clog2(N + 1);
    localparam int c_BCD_W  = c_BCD_DIGIT_W * D;

    generate
        if (!(64'(10) ** D > (64'(1) << N) - 64'(1))) begin : g_bad_digit_count
            $error("binary_to_bcd_seq: D=%0d digits cannot hold a %0d-bit value", D, N);
        end
    endgenerate

    state_t                r_state_q,   w_state_d;
    logic [c_ITER_W-1:0]   r_iter_q,    w_iter_d;
    logic [N-1:0]          r_shift_q,   w_shift_d;
    logic [c_BCD_W-1:0]    r_scratch_q, w_scratch_d;
    logic [c_BCD_W-1:0]    r_bcd_q,     w_bcd_d;
    logic                  r_done_q,    w_done_d;
    logic [c_BCD_W-1:0]    w_adjusted;
    logic [c_BCD_W-1:0]    w_shifted;

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_digit
            bcd_digit_adjust u_adjust (
                .i_digit (r_scratch_q[gi*c_BCD_DIGIT_W +: c_BCD_DIGIT_W]),
                .o_digit (w_adjusted [gi*c_BCD_DIGIT_W +: c_BCD_DIGIT_W])
            );
        end
    endgenerate

    // Binary MSB enters the units digit LSB as the whole chain shifts left.
    assign w_shifted = {w_adjusted[c_BCD_W-2:0], r_shift_q[N-1]};

    always_comb begin
        w_state_d   = r_state_q;
        w_iter_d    = r_iter_q;
        w_shift_d   = r_shift_q;
        w_scratch_d = r_scratch_q;
        w_bcd_d     = r_bcd_q;
        w_done_d    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_shift_d   = bus.bin;
                    w_scratch_d = '0;
                    w_iter_d    = '0;
                    w_state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                w_scratch_d = w_shifted;
                w_shift_d   = r_shift_q << 1;
                w_iter_d    = r_iter_q + c_ITER_W'(1);
                if (r_iter_q == c_ITER_W'(N - 1)) begin
                    w_bcd_d   = w_shifted;
                    w_done_d  = 1'b1;
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= S_IDLE;
            r_iter_q    <= '0;
            r_shift_q   <= '0;
            r_scratch_q <= '0;
            r_bcd_q     <= '0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_iter_q    <= w_iter_d;
            r_shift_q   <= w_shift_d;
            r_scratch_q <= w_scratch_d;
            r_bcd_q     <= w_bcd_d;
            r_done_q    <= w_done_d;
        end
    end

    assign bus.busy = (r_state_q == S_CONVERT);
    assign bus.done = r_done_q;
    assign bus.bcd  = r_bcd_q;

endmodule : binary_to_bcd_seq
`default_nettype wire
